// File: rtl/dct_2d_seq.sv
// rtl/dct_2d_seq.sv - sequencer running one shared 8-point 1-D DCT datapath as a separable 8x8 2-D DCT
//
// Purpose:
//   Accepts 8 input rows over a valid/ready handshake and issues them to an external 8-point
//   1-D DCT datapath. It captures the 8 row results in a transpose buffer, then replays the
//   buffer columns through the same datapath and emits the 8 result columns. The datapath
//   carries no valid signal, so a tag pipe of LAT+1 stages runs alongside it. The tag pipe
//   tracks what is at the datapath output in each cycle.
//
// Ports:
//   clk       in   clock, all state on rising edge
//   rst_n     in   asynchronous active-low reset
//   i_valid   in   input row valid
//   i_ready   out  input row accepted when i_valid & i_ready
//   i_row     in   input row, element [c] = column c (signed W)
//   dp_x_in   out  registered datapath input (8 x W)
//   dp_x_out  in   datapath output (8 x DW), LAT cycles after dp_x_in
//   o_valid   out  output column valid (no backpressure)
//   o_col     out  2-D result column, element [r] = row r
//   o_idx     out  column index of o_col
//   o_last    out  high with column 7 of each block
//   busy      out  block has work pending or in flight

module dct_2d_seq #(
    parameter int W   = 16,
    parameter int DW  = 8,
    parameter int LAT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [7:0][W-1:0]     i_row,
    output logic [7:0][W-1:0]     dp_x_in,
    input  logic [7:0][DW-1:0]    dp_x_out,
    output logic                  o_valid,
    output logic [7:0][DW-1:0]    o_col,
    output logic [2:0]            o_idx,
    output logic                  o_last,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ROW_IN   = 2'd0,
        ROW_WAIT = 2'd1,
        COL_OUT  = 2'd2
    } state_t;

    // One tag per datapath slot; tag_q[LAT] describes what dp_x_out carries this cycle.
    typedef struct packed {
        logic       vld;
        logic       is_col;
        logic [2:0] idx;
    } tag_t;

    state_t                 state_q, state_d;
    logic [2:0]             row_cnt_q, row_cnt_d;
    logic [2:0]             col_cnt_q, col_cnt_d;
    logic [7:0][W-1:0]      dp_x_in_q, dp_x_in_d;
    tag_t                   tag_q [0:LAT];
    tag_t                   tag_in_d;
    tag_t                   tag_out;

    // Transpose buffer: tbuf_q[row][col]. Contents need no reset.
    logic [7:0][DW-1:0]     tbuf_q [0:7];

    logic                   o_valid_q;
    logic [7:0][DW-1:0]     o_col_q;
    logic [2:0]             o_idx_q;
    logic                   o_last_q;
    logic                   in_flight;

    assign tag_out = tag_q[LAT];

    // Next-state and datapath issue
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        dp_x_in_d = '0;
        tag_in_d  = '0;
        i_ready   = 1'b0;

        case (state_q)
            ROW_IN: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    dp_x_in_d = i_row;
                    tag_in_d  = '{vld: 1'b1, is_col: 1'b0, idx: row_cnt_q};
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == 3'd7) begin
                        state_d = ROW_WAIT;
                    end
                end
            end

            ROW_WAIT: begin
                // Row 7's result reaches the buffer at the next edge. COL_OUT reads start one cycle later.
                if (tag_out.vld && !tag_out.is_col && tag_out.idx == 3'd7) begin
                    state_d = COL_OUT;
                end
            end

            COL_OUT: begin
                for (int r = 0; r < 8; r++) begin
                    dp_x_in_d[r] = W'($signed(tbuf_q[r][col_cnt_q]));
                end
                tag_in_d  = '{vld: 1'b1, is_col: 1'b1, idx: col_cnt_q};
                col_cnt_d = col_cnt_q + 3'd1;
                if (col_cnt_q == 3'd7) begin
                    state_d = ROW_IN;
                end
            end

            default: begin
                state_d = ROW_IN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ROW_IN;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            dp_x_in_q <= '0;
            for (int i = 0; i <= LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            dp_x_in_q <= dp_x_in_d;
            tag_q[0]  <= tag_in_d;
            for (int i = 1; i <= LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Row results land in the transpose buffer as they leave the datapath.
    always_ff @(posedge clk) begin
        if (tag_out.vld && !tag_out.is_col) begin
            tbuf_q[tag_out.idx] <= dp_x_out;
        end
    end

    // Column results are registered once. o_col and o_idx hold between columns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_col_q   <= '0;
            o_idx_q   <= '0;
            o_last_q  <= 1'b0;
        end else begin
            o_valid_q <= tag_out.vld && tag_out.is_col;
            o_last_q  <= 1'b0;
            if (tag_out.vld && tag_out.is_col) begin
                o_col_q  <= dp_x_out;
                o_idx_q  <= tag_out.idx;
                o_last_q <= (tag_out.idx == 3'd7);
            end
        end
    end

    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i <= LAT; i++) begin
            in_flight = in_flight | tag_q[i].vld;
        end
    end

    assign busy    = (state_q != ROW_IN) || in_flight || (row_cnt_q != 3'd0);
    assign dp_x_in = dp_x_in_q;
    assign o_valid = o_valid_q;
    assign o_col   = o_col_q;
    assign o_idx   = o_idx_q;
    assign o_last  = o_last_q;

endmodule

// File: tb/tb_dct_2d_seq.sv
// tb/tb_dct_2d_seq.sv - self-checking bench for dct_2d_seq with a behavioural DCT datapath and 2-D golden model

module tb_dct_2d_seq;

    localparam int W   = 16;
    localparam int DW  = 8;
    localparam int LAT = 8;

    typedef logic [7:0][W-1:0]  row_t;
    typedef logic [7:0][DW-1:0] col_t;
    typedef struct packed {
        col_t       col;
        logic [2:0] idx;
        int         t;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   i_valid = 1'b0;
    logic   i_ready;
    row_t   i_row = '0;
    row_t   dp_x_in;
    col_t   dp_x_out;
    logic   o_valid;
    col_t   o_col;
    logic [2:0] o_idx;
    logic   o_last;
    logic   busy;

    int     n_tests = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     cyc0 = 0;
    logic   stub_mode = 1'b0;

    row_t   rq [$];
    int     aq [$];
    exp_t   eq [$];

    int cm [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };

    always #5 clk = ~clk;

    dct_2d_seq #(.W(W), .DW(DW), .LAT(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_row    (i_row),
        .dp_x_in  (dp_x_in),
        .dp_x_out (dp_x_out),
        .o_valid  (o_valid),
        .o_col    (o_col),
        .o_idx    (o_idx),
        .o_last   (o_last),
        .busy     (busy)
    );

    // Integer 8-point DCT, result wrapped to DW bits.
    function automatic col_t dct8(input row_t x);
        col_t y;
        int   acc;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) begin
                acc = acc + cm[k][n] * int'($signed(x[n]));
            end
            y[k] = DW'(acc >>> 9);
        end
        return y;
    endfunction

    function automatic col_t stub8(input row_t x);
        col_t y;
        for (int c = 0; c < 8; c++) begin
            y[c] = x[c][DW-1:0];
        end
        return y;
    endfunction

    function automatic row_t rand_row();
        row_t x;
        for (int c = 0; c < 8; c++) begin
            x[c] = W'(int'($urandom_range(0, 255)) - 128);
        end
        return x;
    endfunction

    // External datapath: LAT cycles from the dp_x_in register to dp_x_out.
    row_t pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= dp_x_in;
        for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    always_comb begin
        dp_x_out = stub_mode ? stub8(pipe[LAT-1]) : dct8(pipe[LAT-1]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - cyc0);
        end
    endtask

    // Queue one block: rows to drive, expected accept cycles and the eight expected output columns.
    task automatic add_block(input int acc0, input int step, input bit stub);
        row_t blk [8];
        col_t rr [8];
        row_t cv;
        exp_t e;
        for (int r = 0; r < 8; r++) begin
            blk[r] = stub ? '0 : rand_row();
            if (stub) begin
                for (int c = 0; c < 8; c++) begin
                    blk[r][c] = W'(r * 8 + c);
                end
            end
            rq.push_back(blk[r]);
            aq.push_back(acc0 + r * step);
            rr[r] = dct8(blk[r]);
        end
        for (int k = 0; k < 8; k++) begin
            if (stub) begin
                for (int r = 0; r < 8; r++) begin
                    e.col[r] = DW'(r * 8 + k);
                end
            end else begin
                for (int r = 0; r < 8; r++) begin
                    cv[r] = W'($signed(rr[r][k]));
                end
                e.col = dct8(cv);
            end
            e.idx = 3'(k);
            e.t   = acc0 + 7 * step + 20 + k;
            eq.push_back(e);
        end
    endtask

    // Advance to the next falling edge and score any output column present there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (o_valid) begin
            if (eq.size() == 0) begin
                check("spurious_o_valid", 64'(o_valid), 64'(0));
            end else begin
                e = eq.pop_front();
                check("o_col", 64'(o_col), 64'(e.col));
                check("o_idx", 64'(o_idx), 64'(e.idx));
                check("o_last", 64'(o_last), 64'(e.idx == 3'd7));
                check("o_cycle", 64'(cyc - cyc0), 64'(e.t));
            end
        end
    endtask

    // Drive queued rows (mode 0: valid always, mode 1: valid on even cycles) and drain outputs.
    task automatic run(input int mode, input int t7);
        int n;
        int rel;
        n = 0;
        cyc0 = cyc + 1;
        while ((rq.size() != 0 || eq.size() != 0) && n < 300) begin
            tick();
            n++;
            rel = cyc - cyc0;
            if (rel > t7 && rel <= t7 + 18) begin
                check("i_ready_window", 64'(i_ready), 64'(rel == t7 + 18));
            end
            if (rq.size() != 0 && (mode == 0 || rel % 2 == 0)) begin
                i_valid = 1'b1;
                i_row   = rq[0];
                if (i_ready) begin
                    void'(rq.pop_front());
                    if (aq.size() != 0) begin
                        check("accept_cycle", 64'(rel), 64'(aq.pop_front()));
                    end
                end
            end else begin
                i_valid = 1'b0;
                i_row   = rand_row();
            end
        end
        check("drained", 64'(n < 300), 64'(1));
        i_valid = 1'b0;
        repeat (6) tick();
        check("busy_idle", 64'(busy), 64'(0));
        aq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset and release
        rst_n = 1'b0;
        repeat (3) tick();
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("rst_i_ready", 64'(i_ready), 64'(1));
            check("rst_o_valid", 64'(o_valid), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_dp_x_in", 64'(dp_x_in != '0), 64'(0));
        end

        // 2. Single block, i_valid held high
        add_block(0, 1, 1'b0);
        run(0, 7);

        // 3. Transpose check through a pass-through datapath
        stub_mode = 1'b1;
        add_block(0, 1, 1'b1);
        run(0, 7);
        stub_mode = 1'b0;

        // 4. i_valid toggling 1010..
        add_block(0, 2, 1'b0);
        run(1, 14);

        // 5. Back-to-back blocks
        add_block(0, 1, 1'b0);
        add_block(25, 1, 1'b0);
        run(0, 7);

        // 6. Reset after 5 accepted rows, then a clean block
        begin
            int acc;
            int n;
            add_block(0, 1, 1'b0);
            aq.delete();
            eq.delete();
            acc = 0;
            n = 0;
            cyc0 = cyc + 1;
            while (acc < 5 && n < 50) begin
                tick();
                n++;
                i_valid = 1'b1;
                i_row   = rq[0];
                if (i_ready) begin
                    void'(rq.pop_front());
                    acc++;
                end
            end
            tick();
            i_valid = 1'b0;
            check("pre_rst_busy", 64'(busy), 64'(1));
            rst_n = 1'b0;
            #1;
            check("mid_rst_i_ready", 64'(i_ready), 64'(1));
            check("mid_rst_o_valid", 64'(o_valid), 64'(0));
            check("mid_rst_busy", 64'(busy), 64'(0));
            check("mid_rst_dp_x_in", 64'(dp_x_in), 64'(0));
            check("mid_rst_o_col", 64'(o_col), 64'(0));
            check("mid_rst_o_idx", 64'(o_idx), 64'(0));
            check("mid_rst_o_last", 64'(o_last), 64'(0));
            rq.delete();
            tick();
            rst_n = 1'b1;
            add_block(0, 1, 1'b0);
            run(0, 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
